// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM encoding and strobe width derivation.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module apb_rr_arbiter #(
  parameter int N = 4,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  int pos;

  // Scan from the farthest offset down so the nearest request to ptr wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (req[pos]) begin
        idx   = IdxW'(pos);
        valid = 1'b1;
      end
    end
    if (valid) grant = N'(1) << idx;
  end

endmodule

// File: rtl/apb_requester_arbiter.sv
// APB requester shared by NumReq local masters: round-robin capture, SETUP/ACCESS
// sequencing, wait-state timeout abort and per-requester completion pulses.
module apb_requester_arbiter
  import apb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = 16,
  localparam int StrbWidth    = strb_width(DataWidth)
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NumReq-1:0]             Req,
  input  logic [NumReq-1:0]             ReqWrite,
  input  logic [NumReq*AddrWidth-1:0]   ReqAddr,
  input  logic [NumReq*DataWidth-1:0]   ReqWData,
  input  logic [NumReq*StrbWidth-1:0]   ReqStrb,
  output logic [NumReq-1:0]             Grant,
  output logic [NumReq-1:0]             Done,
  output logic [DataWidth-1:0]          RespData,
  output logic                          RespErr,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [AddrWidth-1:0]          PADDR,
  output logic [DataWidth-1:0]          PWDATA,
  output logic [StrbWidth-1:0]          PSTRB,
  input  logic [DataWidth-1:0]          PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(TimeoutCycles);

  logic [AddrWidth-1:0] req_addr  [NumReq];
  logic [DataWidth-1:0] req_wdata [NumReq];
  logic [StrbWidth-1:0] req_strb  [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign req_addr[gi]  = ReqAddr[gi*AddrWidth +: AddrWidth];
    assign req_wdata[gi] = ReqWData[gi*DataWidth +: DataWidth];
    assign req_strb[gi]  = ReqStrb[gi*StrbWidth +: StrbWidth];
  end

  apb_state_e           state_reg, state_next;
  logic [IdxW-1:0]      ptr_reg, ptr_next;
  logic [CntW-1:0]      cnt_reg, cnt_next;
  logic [NumReq-1:0]    grant_next, done_next;
  logic [DataWidth-1:0] resp_data_next;
  logic                 resp_err_next;
  logic                 psel_next, penable_next, pwrite_next;
  logic [AddrWidth-1:0] paddr_next;
  logic [DataWidth-1:0] pwdata_next;
  logic [StrbWidth-1:0] pstrb_next;
  logic                 finish;

  logic [NumReq-1:0]    win_grant;
  logic [IdxW-1:0]      win_idx;
  logic                 win_valid;

  apb_rr_arbiter #(.N(NumReq)) u_arb (
    .req   (Req),
    .ptr   (ptr_reg),
    .grant (win_grant),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      Grant     <= '0;
      Done      <= '0;
      RespData  <= '0;
      RespErr   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      Grant     <= grant_next;
      Done      <= done_next;
      RespData  <= resp_data_next;
      RespErr   <= resp_err_next;
      PSEL      <= psel_next;
      PENABLE   <= penable_next;
      PWRITE    <= pwrite_next;
      PADDR     <= paddr_next;
      PWDATA    <= pwdata_next;
      PSTRB     <= pstrb_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    grant_next     = Grant;
    done_next      = '0;
    resp_data_next = RespData;
    resp_err_next  = RespErr;
    psel_next      = PSEL;
    penable_next   = PENABLE;
    pwrite_next    = PWRITE;
    paddr_next     = PADDR;
    pwdata_next    = PWDATA;
    pstrb_next     = PSTRB;
    finish         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          grant_next   = win_grant;
          ptr_next     = (win_idx == IdxW'(NumReq - 1)) ? '0 : win_idx + IdxW'(1);
          pwrite_next  = ReqWrite[win_idx];
          paddr_next   = req_addr[win_idx];
          pwdata_next  = req_wdata[win_idx];
          pstrb_next   = ReqWrite[win_idx] ? req_strb[win_idx] : '0;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          cnt_next     = '0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a response on the timeout cycle completes normally.
        if (PREADY) begin
          if (!PWRITE) resp_data_next = PRDATA;
          resp_err_next = PSLVERR;
          finish        = 1'b1;
        end else if (cnt_reg == CntW'(TimeoutCycles - 1)) begin
          resp_err_next = 1'b1;
          finish        = 1'b1;
        end else begin
          cnt_next = cnt_reg + CntW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (finish) begin
      done_next    = Grant;
      grant_next   = '0;
      psel_next    = 1'b0;
      penable_next = 1'b0;
      cnt_next     = '0;
      state_next   = IDLE;
    end
  end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Randomized transaction-level bench for apb_requester_arbiter with a round-robin
// and completion-timing reference model.
module tb_apb_requester_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic [3:0]   Req;
  logic [3:0]   ReqWrite;
  logic [127:0] ReqAddr;
  logic [127:0] ReqWData;
  logic [15:0]  ReqStrb;
  logic [3:0]   Grant;
  logic [3:0]   Done;
  logic [31:0]  RespData;
  logic         RespErr;
  logic         PSEL, PENABLE, PWRITE;
  logic [31:0]  PADDR, PWDATA;
  logic [3:0]   PSTRB;
  logic [31:0]  PRDATA;
  logic         PREADY, PSLVERR;

  apb_requester_arbiter #(
    .NumReq(NR), .DataWidth(32), .AddrWidth(32), .TimeoutCycles(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .Req(Req), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData), .ReqStrb(ReqStrb),
    .Grant(Grant), .Done(Done), .RespData(RespData), .RespErr(RespErr),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic        wr_a   [NR];
  logic [31:0] addr_a [NR];
  logic [31:0] wd_a   [NR];
  logic [3:0]  st_a   [NR];

  int          exp_ptr = 0;
  logic [31:0] exp_rd  = '0;
  int          txn_no  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk();
    @(posedge PCLK);
    #1;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < NR; i++) begin
      wr_a[i]   = 1'($urandom_range(0, 1));
      addr_a[i] = $urandom;
      wd_a[i]   = $urandom;
      st_a[i]   = 4'($urandom);
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NR; i++) begin
      ReqWrite[i]          = wr_a[i];
      ReqAddr[i*32 +: 32]  = addr_a[i];
      ReqWData[i*32 +: 32] = wd_a[i];
      ReqStrb[i*4 +: 4]    = st_a[i];
    end
  endtask

  // One full transfer; wt = ACCESS cycles before PREADY (>= TO means never).
  task automatic run_txn(input logic [3:0] mask, input int wt,
                         input logic [31:0] rd, input logic er);
    int w;
    logic cw;
    logic [31:0] ca, cd;
    logic [3:0] cs;
    int acc;
    bit got;
    int exp_acc;
    w = -1;
    for (int k = 0; k < NR; k++) begin
      int p;
      p = (exp_ptr + k) % NR;
      if (w < 0 && mask[p]) w = p;
    end
    Req = mask;
    drive_fields();
    cw = wr_a[w];
    ca = addr_a[w];
    cd = wd_a[w];
    cs = cw ? st_a[w] : 4'h0;
    PREADY = 1'b0;

    wait_clk();
    chk("grant", Grant, 64'(1) << w);
    chk("done_idle", Done, 0);
    chk("setup_phase", {PSEL, PENABLE}, 2'b10);
    chk("paddr", PADDR, ca);
    chk("pwrite", PWRITE, cw);
    chk("pwdata", PWDATA, cd);
    chk("pstrb", PSTRB, cs);
    exp_ptr = (w + 1) % NR;

    // Requesters may change fields or drop Req once granted.
    randomize_fields();
    drive_fields();
    Req = 4'($urandom);

    wait_clk();
    chk("access_phase", {PSEL, PENABLE}, 2'b11);
    chk("paddr_hold", PADDR, ca);
    chk("pwdata_hold", PWDATA, cd);
    chk("grant_hold", Grant, 64'(1) << w);

    acc = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      PREADY = (c == wt);
      PRDATA = (c == wt) ? rd : 32'($urandom);
      PSLVERR = (c == wt) ? er : 1'($urandom_range(0, 1));
      acc++;
      wait_clk();
      if (Done != 4'h0) got = 1'b1;
    end
    PREADY = 1'b0;
    Req = 4'h0;
    if (!got) begin
      chk("done_seen", 0, 1);
    end else begin
      exp_acc = (wt < TO) ? wt + 1 : TO;
      if (wt < TO && !cw) exp_rd = rd;
      chk("access_cycles", acc, exp_acc);
      chk("done", Done, 64'(1) << w);
      chk("resp_err", RespErr, (wt < TO) ? er : 1'b1);
      chk("resp_data", RespData, exp_rd);
      chk("bus_released", {PSEL, PENABLE, Grant}, 0);
    end
    txn_no++;
    $display("txn %0d: req=%b winner=%0d %s addr=0x%08h wait=%0d cycles=%0d err=%0d rdata=0x%08h",
             txn_no, mask, w, cw ? "WR" : "RD", ca, wt, acc, RespErr, RespData);
  endtask

  initial begin
    PRESETn = 1'b0;
    Req = '0; ReqWrite = '0; ReqAddr = '0; ReqWData = '0; ReqStrb = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    randomize_fields();
    repeat (2) wait_clk();
    chk("rst_ctrl", {PSEL, PENABLE, PWRITE, RespErr}, 0);
    chk("rst_grant_done", {Grant, Done}, 0);
    chk("rst_data", {PADDR, RespData}, 0);
    PRESETn = 1'b1;
    wait_clk();

    // Single write from requester 0.
    wr_a[0] = 1'b1; addr_a[0] = 32'h10; wd_a[0] = 32'hDEADBEEF; st_a[0] = 4'hF;
    run_txn(4'b0001, 0, 32'h0, 1'b0);

    // Read from requester 2 with three wait states.
    randomize_fields();
    wr_a[2] = 1'b0; addr_a[2] = 32'h40;
    run_txn(4'b0100, 3, 32'h12345678, 1'b0);

    // All requesting, then a subset.
    for (int i = 0; i < 5; i++) begin
      randomize_fields();
      run_txn(4'b1111, $urandom_range(0, 2), $urandom, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      randomize_fields();
      run_txn(4'b1010, 0, $urandom, 1'b0);
    end

    // Timeout, response on the timeout cycle, and slave error on a read.
    randomize_fields();
    run_txn(4'($urandom_range(1, 15)), TO, $urandom, 1'b0);
    randomize_fields();
    run_txn(4'($urandom_range(1, 15)), TO - 1, $urandom, 1'b0);
    randomize_fields();
    for (int i = 0; i < NR; i++) wr_a[i] = 1'b0;
    run_txn(4'($urandom_range(1, 15)), 1, 32'hA5A5_0001, 1'b1);
    randomize_fields();
    run_txn(4'($urandom_range(1, 15)), 0, $urandom, 1'b0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      randomize_fields();
      run_txn(4'($urandom_range(1, 15)),
              ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5)),
              $urandom, 1'($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of an ACCESS phase.
    randomize_fields();
    drive_fields();
    Req = 4'b0100;
    wait_clk();
    wait_clk();
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_bus", {PSEL, PENABLE}, 0);
    chk("rst_mid_grant", Grant, 0);
    chk("rst_mid_done", Done, 0);
    Req = 4'b1111;
    repeat (2) begin
      wait_clk();
      chk("rst_no_done", Done, 0);
    end
    PRESETn = 1'b1;
    exp_ptr = 0;
    exp_rd  = '0;
    randomize_fields();
    run_txn(4'b1111, 0, $urandom, 1'b0);
    randomize_fields();
    run_txn(4'b1111, 1, $urandom, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
